// File: rtl/risc_controller_if.sv
// risc_controller_if: control inputs and phase/strobe outputs of the RISC phase sequencer
interface risc_controller_if #(
  parameter int OPC_W   = 3,
  parameter int PHASE_W = 3
);
  logic               en;
  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic [PHASE_W-1:0] phase;
  logic               sel;
  logic               rd;
  logic               ld_ir;
  logic               inc_pc;
  logic               ld_pc;
  logic               ld_ac;
  logic               wr;
  logic               data_e;
  logic               halt;
  modport master (
    output en, opcode, zero,
    input  phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );
  modport slave (
    input  en, opcode, zero,
    output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );
endinterface

// File: rtl/risc_controller.sv
// risc_controller: 8-phase instruction sequencer and control decoder for the 8-bit RISC CPU
module risc_controller (
  input  logic               clk,
  input  logic               rst,
  risc_controller_if.slave   bus
);
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_e;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   alu_op, stb, lvl;
  // phase and halted state register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end
  // advance one phase per enabled clock; HLT in OP_ADDR latches halted and the phase stops at OP_FETCH
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (bus.en && !halted_q) begin
      phase_d  = phase_e'(phase_q + 3'd1);
      halted_d = (phase_q == OP_ADDR) && (bus.opcode == HLT);
    end
  end
  // levels follow the phase decode; one-shot strobes are suppressed while stalled, halted or in reset
  always_comb begin
    alu_op     = bus.opcode inside {ADD, AND, XOR, LDA};
    stb        = bus.en && !rst && !halted_q;
    lvl        = !halted_q;
    bus.phase  = phase_q;
    bus.sel    = lvl && (phase_q < OP_ADDR);
    bus.rd     = lvl && ((phase_q inside {INST_FETCH, INST_LOAD, IDLE}) || (phase_q >= OP_FETCH && alu_op));
    bus.ld_ir  = stb && (phase_q inside {INST_LOAD, IDLE});
    bus.inc_pc = stb && (phase_q == OP_ADDR || (phase_q == ALU_OP && bus.opcode == SKZ && bus.zero));
    bus.ld_pc  = stb && bus.opcode == JMP && (phase_q inside {ALU_OP, STORE});
    bus.ld_ac  = stb && alu_op && phase_q == STORE;
    bus.wr     = stb && bus.opcode == STO && phase_q == STORE;
    bus.data_e = lvl && bus.opcode == STO && (phase_q inside {ALU_OP, STORE});
    bus.halt   = halted_q || (phase_q == OP_ADDR && bus.opcode == HLT);
  end
endmodule
